// File: rtl/seven_segment_animations.sv
// seven_segment_animations
// Drives one seven-segment digit with four looping animations. Two push-buttons
// (next animation, speed) go through a 2-flop synchronizer, a debouncer and a
// rising-edge pulse stage. A third input freezes stepping while held.
//
// Ports
//   clk      system clock
//   rst_n    synchronous reset, active HIGH despite the name
//   ena      ignored
//   ui_in    [0] next-animation button, [1] speed button, [2] freeze level
//   uo_out   [6:0] segments a..g, [7] heartbeat decimal point
//   uio_in   ignored
//   uio_out  [1:0] animation index, [3:2] speed, [7:4] zero
//   uio_oe   constant 8'h0F
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a new level
//   BASE_DIV         clocks per animation step at speed 0
//
// Build option
//   SEG_ACTIVE_LOW_EN  when defined, uo_out is inverted for common-anode digits
module seven_segment_animations #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int BASE_DIV        = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_W = $clog2(BASE_DIV * 8 + 1);

  // Synchronizers for the two buttons and the freeze level
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  // Fills with ones after reset; marks when sync2 holds a real pin sample
  logic [1:0] fill_q, fill_d;

  // Per-button debounce state
  logic [1:0]           lvl_q, lvl_d, prev_q, prev_d, armed_q, armed_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           pulse;

  // Animation state
  logic [1:0]       anim_q, anim_d, speed_q, speed_d;
  logic [3:0]       frame_q, frame_d;
  logic             dp_q, dp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
  logic             freeze, tick;
  logic [6:0]       seg;
  logic [7:0]       uo_raw;

  logic unused;
  assign unused = ^{ena, uio_in, ui_in[7:3]};

  function automatic logic [3:0] frame_last(input logic [1:0] a);
    case (a)
      2'd0:    frame_last = 4'd5;
      2'd1:    frame_last = 4'd15;
      2'd2:    frame_last = 4'd7;
      default: frame_last = 4'd1;
    endcase
  endfunction

  function automatic logic [6:0] seg_lut(input logic [1:0] a, input logic [3:0] f);
    logic [6:0] s;
    s = 7'h00;
    case (a)
      2'd0: case (f)
        4'd0: s = 7'h01; 4'd1: s = 7'h02; 4'd2: s = 7'h04;
        4'd3: s = 7'h08; 4'd4: s = 7'h10; 4'd5: s = 7'h20;
        default: s = 7'h00;
      endcase
      2'd1: case (f)
        4'd0:  s = 7'h3F; 4'd1:  s = 7'h06; 4'd2:  s = 7'h5B; 4'd3:  s = 7'h4F;
        4'd4:  s = 7'h66; 4'd5:  s = 7'h6D; 4'd6:  s = 7'h7D; 4'd7:  s = 7'h07;
        4'd8:  s = 7'h7F; 4'd9:  s = 7'h6F; 4'd10: s = 7'h77; 4'd11: s = 7'h7C;
        4'd12: s = 7'h39; 4'd13: s = 7'h5E; 4'd14: s = 7'h79; default: s = 7'h71;
      endcase
      2'd2: case (f)
        4'd0: s = 7'h01; 4'd1: s = 7'h02; 4'd2: s = 7'h40; 4'd3: s = 7'h10;
        4'd4: s = 7'h08; 4'd5: s = 7'h04; 4'd6: s = 7'h40; 4'd7: s = 7'h20;
        default: s = 7'h00;
      endcase
      default: case (f)
        4'd0: s = 7'h7F;
        default: s = 7'h00;
      endcase
    endcase
    return s;
  endfunction

  // Input conditioning
  always_comb begin
    sync1_d  = ui_in[2:0];
    sync2_d  = sync1_q;
    fill_d   = {fill_q[0], 1'b1};
    prev_d   = lvl_q;
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    armed_d  = armed_q;
    pulse    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = ~lvl_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      // A button held through reset must be seen released before it can fire
      armed_d[i] = armed_q[i] | ((fill_q == 2'b11) & ~sync2_q[i]);
      pulse[i]   = lvl_q[i] & ~prev_q[i] & armed_q[i];
    end
  end

  // Step timing and animation state
  always_comb begin
    freeze    = sync2_q[2];
    period_m1 = CNT_W'((BASE_DIV << speed_q) - 1);
    tick      = ~freeze & (cnt_q == period_m1);
    anim_d    = anim_q;
    speed_d   = speed_q;
    frame_d   = frame_q;
    dp_d      = dp_q;
    cnt_d     = cnt_q;
    if (!freeze) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) begin
      frame_d = (frame_q == frame_last(anim_q)) ? 4'd0 : frame_q + 4'd1;
      dp_d    = ~dp_q;
    end
    // A next pulse overrides a coincident tick entirely, including dp
    if (pulse[0]) begin
      anim_d  = anim_q + 2'd1;
      frame_d = 4'd0;
      dp_d    = dp_q;
      cnt_d   = '0;
    end
    if (pulse[1]) begin
      speed_d = speed_q + 2'd1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      fill_q   <= '0;
      lvl_q    <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      db_cnt_q <= '0;
      anim_q   <= '0;
      speed_q  <= '0;
      frame_q  <= '0;
      dp_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      fill_q   <= fill_d;
      lvl_q    <= lvl_d;
      prev_q   <= prev_d;
      armed_q  <= armed_d;
      db_cnt_q <= db_cnt_d;
      anim_q   <= anim_d;
      speed_q  <= speed_d;
      frame_q  <= frame_d;
      dp_q     <= dp_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    seg    = seg_lut(anim_q, frame_q);
    uo_raw = {dp_q, seg};
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign uo_out = ~uo_raw;
`else
  assign uo_out = uo_raw;
`endif
  assign uio_out = {4'b0000, speed_q, anim_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_seven_segment_animations.sv
module tb_seven_segment_animations;
  localparam int D    = 3;
  localparam int BD   = 4;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  seven_segment_animations #(.DEBOUNCE_CYCLES(D), .BASE_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } exp_t;
  exp_t sb[$];

  int checks = 0, passes = 0;
  int n_next_on_tick = 0;

  // Reference model: pin history since the last reset edge, indexed by edge number
  bit raw [3][MAXE];
  bit lvl [2][MAXE];
  bit arm [2][MAXE];
  int k = 0;
  int m_anim = 0, m_speed = 0, m_frame = 0, m_elapsed = 0;
  bit m_dp = 1'b0;
  int len [4];
  logic [6:0] tbl [4][16];

`ifdef SEG_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  // Synchronized view of pin b after edge j: the pin value seen one edge earlier
  function automatic bit syncv(int b, int j);
    if (j >= 2) return raw[b][j-1];
    return 1'b0;
  endfunction

  task automatic model_edge(input bit r, input bit [2:0] in);
    bit p [2];
    bit fz, tick, flip, prv;
    int per;
    exp_t e;
    if (r) begin
      k = 0;
      for (int b = 0; b < 2; b++) begin lvl[b][0] = 1'b0; arm[b][0] = 1'b0; end
      m_anim = 0; m_speed = 0; m_frame = 0; m_elapsed = 0; m_dp = 1'b0;
    end else begin
      k++;
      if (k >= MAXE) begin
        $display("FAIL model_overflow k=%0d required < %0d", k, MAXE);
        $fatal(1);
      end
      for (int b = 0; b < 3; b++) raw[b][k] = in[b];
      for (int b = 0; b < 2; b++) begin
        // Level flips once the last D synchronized samples all disagree with it
        flip = (k >= D);
        for (int j = k - D; j <= k - 1; j++)
          if (j >= 0 && syncv(b, j) == lvl[b][k-1]) flip = 1'b0;
        lvl[b][k] = lvl[b][k-1] ^ flip;
        arm[b][k] = arm[b][k-1] | ((k - 1 >= 2) && !syncv(b, k - 1));
        prv = (k >= 2) ? lvl[b][k-2] : 1'b0;
        p[b] = lvl[b][k-1] && !prv && arm[b][k-1];
      end
      fz   = syncv(2, k - 1);
      per  = BD << m_speed;
      tick = !fz && (m_elapsed + 1 == per);
      if (tick && p[0]) n_next_on_tick++;
      if (tick && !p[0]) begin
        m_frame = (m_frame + 1) % len[m_anim];
        m_dp    = !m_dp;
      end
      if (p[0]) begin m_anim = (m_anim + 1) % 4; m_frame = 0; end
      if (p[1]) m_speed = (m_speed + 1) % 4;
      if (p[0] || p[1] || tick) m_elapsed = 0;
      else if (!fz) m_elapsed++;
    end
    e.uo  = {m_dp, tbl[m_anim][m_frame]} ^ {8{INV}};
    e.uio = {4'b0000, 2'(m_speed), 2'(m_anim)};
    e.oe  = 8'h0F;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit b0, input bit b1, input bit fz, input bit r = 1'b0);
    @(negedge clk);
    rst_n  = r;
    ena    = 1'($urandom);
    uio_in = 8'($urandom);
    ui_in  = {5'($urandom), fz, b1, b0};
    model_edge(r, {fz, b1, b0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input int btn, input int hold, input int rel);
    for (int i = 0; i < hold; i++) cyc(btn == 0, btn == 1, 1'b0);
    idle(rel);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle after an issued edge the DUT presents new outputs
  exp_t ex;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        checks++;
        if (uo_out === ex.uo) passes++;
        else $display("FAIL uo_out t=%0t got %h exp %h", $time, uo_out, ex.uo);
        checks++;
        if (uio_out === ex.uio) passes++;
        else $display("FAIL uio_out t=%0t got %h exp %h", $time, uio_out, ex.uio);
        checks++;
        if (uio_oe === ex.oe) passes++;
        else $display("FAIL uio_oe t=%0t got %h exp %h", $time, uio_oe, ex.oe);
      end
    end
  end

  initial begin
    len = '{6, 16, 8, 2};
    tbl[0] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h00, 7'h00,
               7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    tbl[1] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    tbl[2] = '{7'h01, 7'h02, 7'h40, 7'h10, 7'h08, 7'h04, 7'h40, 7'h20,
               7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    tbl[3] = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
               7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // Spin after reset
    do_reset();
    idle(30);
    // Next animation: hex count, long enough to wrap
    press(0, 10, 10);
    idle(70);
    // Short glitch, then a long hold giving one pulse
    press(0, 2, 10);
    press(0, 50, 10);
    // Speed twice -> period 16
    press(1, 8, 8);
    press(1, 8, 40);
    // Freeze
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1);
    idle(20);
    // Aim a next pulse at the edge of a tick (pulse lands D+2 edges after press)
    for (int i = 0; i < 40 && ((BD << m_speed) - m_elapsed) != D + 3; i++) idle(1);
    press(0, 8, 20);
    // Reset while the button is held: must release and re-press
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    idle(10);
    press(0, 8, 10);

    // Randomized phase
    for (int r = 0; r < 30; r++) begin
      if (r % 6 == 0) do_reset();
      for (int s = 0; s < 8; s++) begin
        int hold;
        bit b0, b1, fz;
        hold = $urandom_range(1, 12);
        b0 = 1'($urandom);
        b1 = ($urandom_range(0, 3) == 0);
        fz = ($urandom_range(0, 5) == 0);
        for (int i = 0; i < hold; i++) cyc(b0, b1, fz);
        idle($urandom_range(0, 10));
      end
    end

    // Drain the scoreboard with a bound
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    if (n_next_on_tick == 0) $display("note: no next pulse coincided with a tick");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
